// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// No logic; imported by pc_next_logic and instruction_fetch.
// No flow control of its own.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP           = 32'd4;

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC and IF/ID action select for the fetch stage.
// Purely combinational, zero latency.
// Stall holds the PC; redirect overrides stall; halt and trap freeze everything.
// Ports: run_i (FSM in RUN), halt_i, redirect_i, redirect_target_i, stall_i,
//        flush_i, pc_i -> next_pc_o, load_ifid_o, bubble_o, trap_o.
module pc_next_logic
  import fetch_pkg::*;
(
  input  logic        run_i,
  input  logic        halt_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_target_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  output logic [31:0] next_pc_o,
  output logic        load_ifid_o,
  output logic        bubble_o,
  output logic        trap_o
);

  logic [31:0] pc_plus4;
  assign pc_plus4 = pc_i + PC_STEP;  // wraps modulo 2^32 by width

  always_comb begin
    next_pc_o   = pc_i;
    load_ifid_o = 1'b0;
    bubble_o    = 1'b0;
    trap_o      = 1'b0;
    if (run_i) begin
      if (halt_i) begin
        // Halt wins over everything, including a misaligned redirect.
        next_pc_o = pc_i;
      end else if (redirect_i && (redirect_target_i[1:0] != 2'b00)) begin
        trap_o = 1'b1;
      end else if (redirect_i) begin
        next_pc_o = redirect_target_i;
        bubble_o  = 1'b1;
      end else if (stall_i) begin
        // PC holds; IF/ID either holds or is squashed.
        bubble_o = flush_i;
      end else if (flush_i) begin
        next_pc_o = pc_plus4;
        bubble_o  = 1'b1;
      end else begin
        next_pc_o   = pc_plus4;
        load_ifid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives a combinational imem, registers IF/ID.
// Latency: 1 cycle from imem_address to if_id_* outputs.
// Stall holds PC and IF/ID; flush/redirect insert a bubble; halt/trap stop fetch.
// Ports: clk, rst_n; control start/halt/stall/flush/redirect/redirect_target;
//        imem_address/imem_instruction; IF/ID outputs, fetch_count, running,
//        misaligned_err (sticky until restart from HALT).
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count,
  output logic        running,
  output logic        misaligned_err
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  ifpc_q, ifpc_d;
  logic [31:0]  ifpc4_q, ifpc4_d;
  logic [31:0]  cnt_q, cnt_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;

  logic         run;
  logic [31:0]  next_pc;
  logic         load_ifid;
  logic         bubble;
  logic         trap;

  assign run = (state_q == RUN);

  pc_next_logic u_pc_next (
    .run_i             (run),
    .halt_i            (halt),
    .redirect_i        (redirect),
    .redirect_target_i (redirect_target),
    .stall_i           (stall),
    .flush_i           (flush),
    .pc_i              (pc_q),
    .next_pc_o         (next_pc),
    .load_ifid_o       (load_ifid),
    .bubble_o          (bubble),
    .trap_o            (trap)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    ifpc4_d = ifpc4_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (start) state_d = RUN;  // PC kept; first capture on the next edge
      end
      HALT: begin
        valid_d = 1'b0;
        if (start) begin
          state_d = RUN;
          pc_d    = RESET_PC;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        if (halt) begin
          state_d = HALT;
          valid_d = 1'b0;
        end else if (trap) begin
          state_d = HALT;
          valid_d = 1'b0;
          err_d   = 1'b1;
        end else begin
          pc_d = next_pc;
          if (bubble) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
          end else if (load_ifid) begin
            instr_d = imem_instruction;
            ifpc_d  = pc_q;
            ifpc4_d = pc_q + PC_STEP;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 32'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      ifpc_q  <= 32'h0;
      ifpc4_q <= 32'h0;
      cnt_q   <= 32'h0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      ifpc4_q <= ifpc4_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign imem_address   = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc       = ifpc_q;
  assign if_id_pc_plus4 = ifpc4_q;
  assign if_id_valid    = valid_q;
  assign fetch_count    = cnt_q;
  assign running        = run;
  assign misaligned_err = err_q;

endmodule
